// File: rtl/zube_wb_arbiter.sv
// Two-master Wishbone classic arbiter: round-robin grant held for a whole
// bus cycle, with a per-access watchdog that forces termination.
module zube_wb_arbiter #(
    parameter int                  ADDR_WIDTH     = 32,
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    m0_cyc_in,
    input  logic                    m0_stb_in,
    input  logic                    m0_we_in,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_in,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_in,
    input  logic [DATA_WIDTH-1:0]   m0_data_in,
    output logic                    m0_ack_out,
    output logic [DATA_WIDTH-1:0]   m0_data_out,

    input  logic                    m1_cyc_in,
    input  logic                    m1_stb_in,
    input  logic                    m1_we_in,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_in,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_in,
    input  logic [DATA_WIDTH-1:0]   m1_data_in,
    output logic                    m1_ack_out,
    output logic [DATA_WIDTH-1:0]   m1_data_out,

    output logic                    s_cyc_out,
    output logic                    s_stb_out,
    output logic                    s_we_out,
    output logic [DATA_WIDTH/8-1:0] s_sel_out,
    output logic [ADDR_WIDTH-1:0]   s_addr_out,
    output logic [DATA_WIDTH-1:0]   s_data_out,
    input  logic                    s_ack_in,
    input  logic [DATA_WIDTH-1:0]   s_data_in,

    output logic [1:0]              grant_out,
    output logic                    timeout_out,
    input  logic                    timeout_clear_in
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_last;
    logic [CW-1:0]   r_wd;
    logic            r_timeout;

    logic            w_req0;
    logic            w_req1;
    logic            w_g0;
    logic            w_g1;
    logic            w_cyc;
    logic            w_stb;
    logic            w_expire;
    logic            w_ack;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_req0 = m0_cyc_in & m0_stb_in;
    assign w_req1 = m1_cyc_in & m1_stb_in;
    assign w_g0   = (r_state == GNT0);
    assign w_g1   = (r_state == GNT1);

    always_comb begin
        w_cyc      = 1'b0;
        w_stb      = 1'b0;
        s_we_out   = 1'b0;
        s_sel_out  = '0;
        s_addr_out = '0;
        s_data_out = '0;
        if (w_g0) begin
            w_cyc      = m0_cyc_in;
            w_stb      = m0_stb_in;
            s_we_out   = m0_we_in;
            s_sel_out  = m0_sel_in;
            s_addr_out = m0_addr_in;
            s_data_out = m0_data_in;
        end else if (w_g1) begin
            w_cyc      = m1_cyc_in;
            w_stb      = m1_stb_in;
            s_we_out   = m1_we_in;
            s_sel_out  = m1_sel_in;
            s_addr_out = m1_addr_in;
            s_data_out = m1_data_in;
        end
    end

    // A slave ack landing on the expiry cycle wins over the watchdog.
    assign w_expire = w_cyc & w_stb & ~s_ack_in & (r_wd == WD_LAST);
    assign w_ack    = s_ack_in | w_expire;
    assign w_rdata  = w_expire ? TIMEOUT_DATA : s_data_in;

    assign s_cyc_out   = w_cyc;
    assign s_stb_out   = w_stb & ~w_expire;
    assign m0_ack_out  = w_g0 & w_ack;
    assign m1_ack_out  = w_g1 & w_ack;
    assign m0_data_out = w_g0 ? w_rdata : '0;
    assign m1_data_out = w_g1 ? w_rdata : '0;
    assign grant_out   = {w_g1, w_g0};
    assign timeout_out = r_timeout;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_next = r_last ? GNT0 : GNT1;
                end else if (w_req0) begin
                    w_next = GNT0;
                end else if (w_req1) begin
                    w_next = GNT1;
                end
            end
            GNT0: if (!m0_cyc_in) w_next = IDLE;
            GNT1: if (!m1_cyc_in) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_g0 && !m0_cyc_in) r_last <= 1'b0;
            if (w_g1 && !m1_cyc_in) r_last <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd <= '0;
        end else if (w_cyc && w_stb && !s_ack_in && !w_expire) begin
            r_wd <= r_wd + 1'b1;
        end else begin
            r_wd <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_expire) begin
            r_timeout <= 1'b1;
        end else if (timeout_clear_in) begin
            r_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zube_wb_arbiter.sv
// Bench for zube_wb_arbiter: directed scenarios plus random traffic,
// all checked each cycle against a transaction-level model.
module tb_zube_wb_arbiter;

    localparam int T = 8;
    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        mc[2];
    logic        ms[2];
    logic        mw[2];
    logic [3:0]  msel[2];
    logic [31:0] maddr[2];
    logic [31:0] mdat[2];
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rd, m1_rd;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_wdat;
    logic        s_ack;
    logic [31:0] s_rdat;
    logic [1:0]  grant;
    logic        tout;
    logic        tclr;

    int n_checks = 0;
    int n_errors = 0;

    int owner;
    int last;
    int wd;
    bit tflag;

    always #5 clk = ~clk;

    zube_wb_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TO_DATA)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_cyc_in(mc[0]), .m0_stb_in(ms[0]), .m0_we_in(mw[0]),
        .m0_sel_in(msel[0]), .m0_addr_in(maddr[0]), .m0_data_in(mdat[0]),
        .m0_ack_out(m0_ack), .m0_data_out(m0_rd),
        .m1_cyc_in(mc[1]), .m1_stb_in(ms[1]), .m1_we_in(mw[1]),
        .m1_sel_in(msel[1]), .m1_addr_in(maddr[1]), .m1_data_in(mdat[1]),
        .m1_ack_out(m1_ack), .m1_data_out(m1_rd),
        .s_cyc_out(s_cyc), .s_stb_out(s_stb), .s_we_out(s_we),
        .s_sel_out(s_sel), .s_addr_out(s_addr), .s_data_out(s_wdat),
        .s_ack_in(s_ack), .s_data_in(s_rdat),
        .grant_out(grant), .timeout_out(tout),
        .timeout_clear_in(tclr)
    );

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = 1;
        wd    = 0;
        tflag = 0;
    endtask

    task automatic set_m(int i, bit c, bit s, bit w, logic [31:0] a, logic [31:0] d);
        mc[i]    = c;
        ms[i]    = s;
        mw[i]    = w;
        msel[i]  = 4'hF;
        maddr[i] = a;
        mdat[i]  = d;
    endtask

    // Compare one cycle at the falling edge, then advance the model.
    task automatic step();
        bit          act, expd, req0, req1;
        logic [31:0] ed;
        logic [1:0]  eg;
        int          o;
        @(negedge clk);
        o    = owner;
        act  = 0;
        expd = 0;
        if (o >= 0) begin
            act  = mc[o] & ms[o];
            expd = act && !s_ack && (wd == T - 1);
        end
        ed = expd ? TO_DATA : s_rdat;
        eg = (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10);
        chk("grant", 64'(grant), 64'(eg));
        chk("s_cyc", 64'(s_cyc), (o < 0) ? 0 : 64'(mc[o]));
        chk("s_stb", 64'(s_stb), (o < 0) ? 0 : 64'(ms[o] & !expd));
        chk("s_we", 64'(s_we), (o < 0) ? 0 : 64'(mw[o]));
        chk("s_sel", 64'(s_sel), (o < 0) ? 0 : 64'(msel[o]));
        chk("s_addr", 64'(s_addr), (o < 0) ? 0 : 64'(maddr[o]));
        chk("s_data", 64'(s_wdat), (o < 0) ? 0 : 64'(mdat[o]));
        chk("m0_ack", 64'(m0_ack), (o == 0) ? 64'(s_ack | expd) : 0);
        chk("m1_ack", 64'(m1_ack), (o == 1) ? 64'(s_ack | expd) : 0);
        chk("m0_data", 64'(m0_rd), (o == 0) ? 64'(ed) : 0);
        chk("m1_data", 64'(m1_rd), (o == 1) ? 64'(ed) : 0);
        chk("timeout", 64'(tout), 64'(tflag));

        req0 = mc[0] & ms[0];
        req1 = mc[1] & ms[1];
        if (o < 0) begin
            wd = 0;
            if (req0 && req1) owner = (last == 1) ? 0 : 1;
            else if (req0) owner = 0;
            else if (req1) owner = 1;
        end else begin
            if (act && !s_ack && !expd) wd = wd + 1;
            else wd = 0;
            if (!mc[o]) begin
                owner = -1;
                last  = o;
            end
        end
        if (expd) tflag = 1;
        else if (tclr) tflag = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic rand_cycle(int ack_pct);
        for (int i = 0; i < 2; i++) begin
            if (mc[i]) begin
                if ($urandom % 8 == 0) mc[i] = 1'b0;
            end else if ($urandom % 4 == 0) begin
                mc[i] = 1'b1;
            end
            ms[i]    = mc[i] ? ($urandom % 4 != 0) : ($urandom % 8 == 0);
            mw[i]    = 1'($urandom);
            msel[i]  = 4'($urandom);
            maddr[i] = $urandom;
            mdat[i]  = $urandom;
        end
        s_ack  = ($urandom % 100) < ack_pct;
        s_rdat = $urandom;
        tclr   = ($urandom % 16 == 0);
        step();
    endtask

    initial begin
        reset  = 1'b1;
        s_ack  = 1'b0;
        s_rdat = 32'h0;
        tclr   = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("rst_grant", 64'(grant), 0);
        chk("rst_s_cyc", 64'(s_cyc), 0);
        chk("rst_timeout", 64'(tout), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        steps(2);

        // Single m0 write, slave acks after two wait cycles
        s_rdat = 32'h5555_0000;
        set_m(0, 1, 1, 1, 32'h3000_0004, 32'h1234_5678);
        steps(3);
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        steps(2);

        // Contention from a fresh reset: m0, idle gap, m1, then m0 again
        do_reset();
        set_m(0, 1, 1, 0, 32'h10, 0);
        set_m(1, 1, 1, 0, 32'h20, 0);
        steps(2);
        chk("tie_first_m0", 64'(grant), 64'(2'b01));
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        steps(3);
        chk("second_m1", 64'(grant), 64'(2'b10));
        set_m(1, 0, 0, 0, 0, 0);
        steps(2);
        set_m(0, 1, 1, 0, 32'h30, 0);
        set_m(1, 1, 1, 0, 32'h40, 0);
        steps(2);
        chk("tie_again_m0", 64'(grant), 64'(2'b01));
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        steps(2);

        // m1 holds cyc across three strobes while m0 waits
        set_m(1, 1, 1, 1, 32'h44, 32'hCAFE_0001);
        steps(2);
        set_m(0, 1, 1, 0, 32'h50, 0);
        for (int k = 0; k < 3; k++) begin
            s_ack = 1'b1;
            step();
            s_ack = 1'b0;
            ms[1] = 1'b0;
            step();
            ms[1] = 1'b1;
        end
        chk("held_m1", 64'(grant), 64'(2'b10));
        set_m(1, 0, 0, 0, 0, 0);
        steps(2);
        chk("after_hold_m0", 64'(grant), 64'(2'b01));
        set_m(0, 0, 0, 0, 0, 0);
        steps(2);

        // Watchdog: no ack ever, then clear coinciding with a new expiry
        set_m(0, 1, 1, 0, 32'h60, 0);
        s_ack = 1'b0;
        steps(1 + T + 1);
        chk("to_set", 64'(tout), 1);
        tclr = 1'b1;
        step();
        tclr = 1'b0;
        for (int k = 0; k < 3 * T; k++) begin
            tclr = (owner == 0) && (wd == T - 1) && tflag;
            step();
        end
        tclr = 1'b0;
        chk("to_clr_set", 64'(tout), 1);
        tclr = 1'b1;
        set_m(0, 0, 0, 0, 0, 0);
        steps(2);
        tclr = 1'b0;
        chk("to_cleared", 64'(tout), 0);

        // Slave acks exactly on the expiry cycle
        set_m(0, 1, 1, 0, 32'h70, 0);
        s_rdat = 32'hA5A5_A5A5;
        for (int k = 0; k < T + 2; k++) begin
            s_ack = (owner == 0) && (wd == T - 1);
            step();
        end
        s_ack = 1'b0;
        chk("ack_wins_to", 64'(tout), 0);
        set_m(0, 0, 0, 0, 0, 0);
        steps(2);

        // Asynchronous reset in the middle of an m1 access
        set_m(1, 1, 1, 1, 32'h80, 32'h1111_2222);
        steps(3);
        s_ack  = 1'b1;
        s_rdat = 32'h7777_8888;
        #1;
        chk("pre_rst_ack", 64'(m1_ack), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_s_cyc", 64'(s_cyc), 0);
        chk("arst_s_stb", 64'(s_stb), 0);
        chk("arst_m1_ack", 64'(m1_ack), 0);
        chk("arst_m1_data", 64'(m1_rd), 0);
        chk("arst_grant", 64'(grant), 0);
        model_reset();
        s_ack = 1'b0;
        set_m(0, 1, 1, 0, 32'h90, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        steps(2);
        chk("arst_tie_m0", 64'(grant), 64'(2'b01));
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        steps(2);

        // Random traffic: responsive slave, then a sluggish one
        for (int k = 0; k < 1500; k++) rand_cycle(40);
        for (int k = 0; k < 1500; k++) rand_cycle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
